// File: rtl/audio_pkg.sv
// Shared audio definitions for the I2S transmitter/receiver pair.
package audio_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;

    // Receiver capture state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } rx_state_e;

    // I2S channel as signalled on LRCLK
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_receiver_if.sv
// Parallel sample-pair output bus of the I2S receiver with status/clear sideband.
interface i2s_receiver_if #(
    parameter int unsigned DATA_W = 16
) ();

    logic [DATA_W-1:0] left_data;
    logic [DATA_W-1:0] right_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              frame_err;
    logic              overrun;
    logic              overrun_clr;

    modport master (
        output left_data,
        output right_data,
        output sample_valid,
        output frame_err,
        output overrun,
        input  sample_ready,
        input  overrun_clr
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  sample_valid,
        input  frame_err,
        input  overrun,
        output sample_ready,
        output overrun_clr
    );

endinterface

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for asynchronous inputs.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the async input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S serial-to-parallel receiver: oversamples codec BCLK/LRCLK/DATA on clk,
// assembles left/right words per frame and holds them on a valid/ready register.
module i2s_receiver
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           aud_bclk,
    input  logic           aud_adclrck,
    input  logic           aud_adcdat,
    i2s_receiver_if.master rx
);

    localparam int unsigned         IDX_W    = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0]    IDX_MAX  = IDX_W'(DATA_W);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DATA_W - 1);

    logic              bclk_s, lr_s, dat_s;
    logic              bclk_d, rise_c;
    logic              rise_q, lr_q, dat_q;
    logic              lr_prev;
    rx_state_e         state;
    logic [IDX_W-1:0]  idx, idx_inc_c;
    logic [DATA_W-1:0] acc, left_hold, word_c;
    logic [DATA_W-1:0] left_q, right_q;
    logic              sv_q, fe_q, ov_q;
    logic              boundary_c, short_c, complete_c, load_c, drop_c;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bclk (.clk(clk), .rst_n(rst_n), .d(aud_bclk),    .q(bclk_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lr   (.clk(clk), .rst_n(rst_n), .d(aud_adclrck), .q(lr_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dat  (.clk(clk), .rst_n(rst_n), .d(aud_adcdat),  .q(dat_s));

    assign rise_c = bclk_s & ~bclk_d;

    // Register BCLK rise together with the LR/data values sampled on it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_d <= 1'b0;
            rise_q <= 1'b0;
            lr_q   <= 1'b0;
            dat_q  <= 1'b0;
        end else begin
            bclk_d <= bclk_s;
            rise_q <= rise_c;
            lr_q   <= lr_s;
            dat_q  <= dat_s;
        end
    end

    // Current word with this rise's bit placed MSB-first; bits past DATA_W fall away
    always_comb begin
        word_c = acc;
        if (idx < IDX_MAX) begin
            word_c = acc | (DATA_W'(dat_q) << (IDX_LAST - idx));
        end
    end

    assign boundary_c = rise_q && (lr_q != lr_prev);
    assign short_c    = (idx < IDX_LAST);
    assign idx_inc_c  = (idx == IDX_MAX) ? IDX_MAX : idx + IDX_W'(1);
    assign complete_c = enable && (state == RIGHT) && boundary_c;
    assign load_c     = complete_c && (!sv_q || rx.sample_ready);
    assign drop_c     = complete_c && !load_c;

    // Capture FSM: alignment to a right-to-left boundary, then left/right word assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            left_hold <= '0;
            lr_prev   <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            fe_q <= 1'b0;
            if (rise_q) begin
                lr_prev <= lr_q;
            end
            if (!enable) begin
                state <= IDLE;
                idx   <= '0;
                acc   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ALIGN;
                        idx   <= '0;
                        acc   <= '0;
                    end
                    ALIGN: begin
                        idx <= '0;
                        acc <= '0;
                        if (rise_q && (lr_prev == CH_RIGHT) && (lr_q == CH_LEFT)) begin
                            state <= LEFT;
                        end
                    end
                    LEFT: begin
                        if (boundary_c) begin
                            left_hold <= word_c;
                            acc       <= '0;
                            idx       <= '0;
                            fe_q      <= short_c;
                            state     <= RIGHT;
                        end else if (rise_q) begin
                            acc <= word_c;
                            idx <= idx_inc_c;
                        end
                    end
                    RIGHT: begin
                        if (boundary_c) begin
                            acc   <= '0;
                            idx   <= '0;
                            fe_q  <= short_c;
                            state <= LEFT;
                        end else if (rise_q) begin
                            acc <= word_c;
                            idx <= idx_inc_c;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Output holding register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q  <= '0;
            right_q <= '0;
            sv_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            if (load_c) begin
                left_q  <= left_hold;
                right_q <= word_c;
                sv_q    <= 1'b1;
            end else if (sv_q && rx.sample_ready) begin
                sv_q <= 1'b0;
            end
            if (drop_c) begin
                ov_q <= 1'b1;
            end else if (rx.overrun_clr) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign rx.left_data    = left_q;
    assign rx.right_data   = right_q;
    assign rx.sample_valid = sv_q;
    assign rx.frame_err    = fe_q;
    assign rx.overrun      = ov_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: I2S frames driven bit by bit, BCLK = clk/16.
module tb_i2s_receiver;

    localparam int unsigned DW   = 16;
    localparam int unsigned SS   = 2;
    localparam int          HALF = 8;

    logic clk = 1'b0;
    logic rst_n, enable, aud_bclk, aud_adclrck, aud_adcdat;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_chk  = 0;
    int   fe_cnt = 0;
    int   fe0;

    always #5 clk = ~clk;

    i2s_receiver_if #(.DATA_W(DW)) rx ();

    i2s_receiver #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .aud_bclk    (aud_bclk),
        .aud_adclrck (aud_adclrck),
        .aud_adcdat  (aud_adcdat),
        .rx          (rx)
    );

    // Count clk cycles with frame_err high; a one-cycle pulse adds exactly one
    always @(posedge clk) begin
        if (rx.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One BCLK period: LR/data change while BCLK is low, receiver samples on the rise
    task automatic send_bit(input logic lr, input logic d);
        aud_adclrck = lr;
        aud_adcdat  = d;
        wait_neg(HALF);
        aud_bclk = 1'b1;
        wait_neg(HALF);
        aud_bclk = 1'b0;
    endtask

    // n bits of channel lr, MSB first; LRCLK flips on the last bit (I2S one-bit delay)
    task automatic send_chan(input logic lr, input logic [23:0] w, input int n);
        logic [23:0] t;
        for (int i = 0; i < n; i++) begin
            t = w >> (n - 1 - i);
            send_bit((i == n - 1) ? ~lr : lr, t[0]);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n);
        send_chan(1'b0, l, n);
        send_chan(1'b1, r, n);
    endtask

    task automatic ack();
        rx.sample_ready = 1'b1;
        wait_neg(1);
        rx.sample_ready = 1'b0;
        wait_neg(1);
    endtask

    initial begin
        logic [23:0] t;
        rst_n           = 1'b0;
        enable          = 1'b1;
        aud_bclk        = 1'b0;
        aud_adclrck     = 1'b0;
        aud_adcdat      = 1'b0;
        rx.sample_ready = 1'b0;
        rx.overrun_clr  = 1'b0;

        // Reset held with toggling inputs
        for (int i = 0; i < 8; i++) begin
            aud_bclk    = ~aud_bclk;
            aud_adclrck = (i % 4) >= 2;
            aud_adcdat  = ~aud_adcdat;
            wait_neg(3);
        end
        aud_bclk = 1'b0;
        check("rst_left",  32'(rx.left_data),    32'h0);
        check("rst_right", 32'(rx.right_data),   32'h0);
        check("rst_valid", 32'(rx.sample_valid), 32'h0);
        check("rst_ferr",  32'(rx.frame_err),    32'h0);
        check("rst_ovr",   32'(rx.overrun),      32'h0);

        // Released but disabled: frames are ignored
        enable = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(2);
        fe0 = fe_cnt;
        send_chan(1'b1, 24'h0, 16);
        send_frame(24'hAAAA, 24'h5555, 16);
        check("dis_valid", 32'(rx.sample_valid), 32'h0);
        check("dis_ferr",  32'(fe_cnt - fe0),    32'h0);

        // Nominal frame after alignment, with latency on the completing rise
        enable = 1'b1;
        wait_neg(4);
        fe0 = fe_cnt;
        send_chan(1'b1, 24'h0, 16);
        send_chan(1'b0, 24'hA5C3, 16);
        t = 24'h1234;
        for (int i = 0; i < 15; i++) begin
            send_bit(1'b1, t[15 - i]);
        end
        aud_adclrck = 1'b0;
        aud_adcdat  = t[0];
        wait_neg(HALF);
        aud_bclk = 1'b1;
        repeat (SS + 1) @(posedge clk);
        #1 check("lat_early", 32'(rx.sample_valid), 32'h0);
        @(posedge clk);
        #1 check("lat_exact", 32'(rx.sample_valid), 32'h1);
        wait_neg(HALF - 3);
        aud_bclk = 1'b0;
        check("nom_left",  32'(rx.left_data),    32'hA5C3);
        check("nom_right", 32'(rx.right_data),   32'h1234);
        check("nom_ferr",  32'(fe_cnt - fe0),    32'h0);
        wait_neg(40);
        check("nom_hold_valid", 32'(rx.sample_valid), 32'h1);
        check("nom_hold_left",  32'(rx.left_data),    32'hA5C3);
        ack();
        check("nom_ack_valid", 32'(rx.sample_valid), 32'h0);

        // Short channels: 12 bits each
        fe0 = fe_cnt;
        send_frame(24'hABC, 24'h123, 12);
        check("short_left",  32'(rx.left_data),    32'hABC0);
        check("short_right", 32'(rx.right_data),   32'h1230);
        check("short_valid", 32'(rx.sample_valid), 32'h1);
        check("short_ferr",  32'(fe_cnt - fe0),    32'h2);
        ack();

        // Long channels: 24 bits each, extra LSBs discarded
        fe0 = fe_cnt;
        send_frame(24'h123456, 24'hFEDCBA, 24);
        check("long_left",  32'(rx.left_data),  32'h1234);
        check("long_right", 32'(rx.right_data), 32'hFEDC);
        check("long_ferr",  32'(fe_cnt - fe0),  32'h0);
        ack();

        // Backpressure: second frame dropped, overrun sticky until cleared
        send_frame(24'h1111, 24'h2222, 16);
        check("bp_first_ovr", 32'(rx.overrun), 32'h0);
        send_frame(24'h3333, 24'h4444, 16);
        check("bp_left",  32'(rx.left_data),    32'h1111);
        check("bp_right", 32'(rx.right_data),   32'h2222);
        check("bp_valid", 32'(rx.sample_valid), 32'h1);
        check("bp_ovr",   32'(rx.overrun),      32'h1);
        rx.overrun_clr = 1'b1;
        wait_neg(1);
        rx.overrun_clr = 1'b0;
        check("bp_ovr_clr", 32'(rx.overrun), 32'h0);
        ack();
        check("bp_ack_valid", 32'(rx.sample_valid), 32'h0);

        // Enable dropped mid-left-word: realign before capturing again
        fe0 = fe_cnt;
        for (int i = 0; i < 8; i++) send_bit(1'b0, i[0]);
        enable = 1'b0;
        wait_neg(4);
        enable = 1'b1;
        wait_neg(4);
        send_chan(1'b1, 24'hFFFF, 16);
        check("en_valid", 32'(rx.sample_valid), 32'h0);
        check("en_ferr",  32'(fe_cnt - fe0),    32'h0);
        send_frame(24'h5A5A, 24'hC3C3, 16);
        check("en_left",  32'(rx.left_data),    32'h5A5A);
        check("en_right", 32'(rx.right_data),   32'hC3C3);
        check("en_valid2", 32'(rx.sample_valid), 32'h1);
        ack();

        // Reset pulsed mid-word
        fe0 = fe_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        rst_n = 1'b0;
        wait_neg(3);
        check("rstm_left",  32'(rx.left_data),    32'h0);
        check("rstm_valid", 32'(rx.sample_valid), 32'h0);
        rst_n = 1'b1;
        wait_neg(2);
        send_chan(1'b1, 24'h00FF, 16);
        check("rstm_valid2", 32'(rx.sample_valid), 32'h0);
        check("rstm_ferr",   32'(fe_cnt - fe0),    32'h0);
        send_frame(24'h0F0F, 24'hF0F0, 16);
        check("rstm_left2",  32'(rx.left_data),  32'h0F0F);
        check("rstm_right2", 32'(rx.right_data), 32'hF0F0);
        check("rstm_ovr",    32'(rx.overrun),    32'h0);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
